// File: rtl/shr_pkg.sv
// Shared definitions for the radix-4 right-shift-by-two unit: operation
// select encodings and the width of the residue carried out of the LSB end.
package shr_pkg;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_PASS  = 2'b11
  } shr_mode_e;

  localparam int RES_W = 2;

endpackage

// File: rtl/shr_2_core.sv
// Purely combinational shift core: produces the next result word and the
// residue (the two bits dropped off the LSB end) for the selected operation.
module shr_2_core
  import shr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       inadd,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_out,
  output logic [RES_W-1:0] next_res
);

  // Select the shifted word; every shifting mode drops in[1:0] into the residue.
  always_comb begin
    next_out = in;
    next_res = in[1:0];
    case (shr_mode_e'(mode))
      MODE_FILL:  next_out = {inadd, in[WIDTH-1:2]};
      MODE_ARITH: next_out = {{2{in[WIDTH-1]}}, in[WIDTH-1:2]};
      MODE_ROT:   next_out = {in[1:0], in[WIDTH-1:2]};
      MODE_PASS: begin
        next_out = in;
        next_res = '0;
      end
      default: begin
        next_out = in;
        next_res = in[1:0];
      end
    endcase
  end

endmodule

// File: rtl/shr_2.sv
// One-stage registered right-shift-by-two unit. The combinational core
// computes the candidate result; this wrapper registers it together with a
// single-cycle valid pulse, so outputs never depend combinationally on inputs.
module shr_2
  import shr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       inadd,
  output logic [WIDTH-1:0] out,
  output logic [RES_W-1:0] res,
  output logic             out_valid
);

  logic [WIDTH-1:0] next_out;
  logic [RES_W-1:0] next_res;

  shr_2_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .in       (in),
    .inadd    (inadd),
    .mode     (mode),
    .next_out (next_out),
    .next_res (next_res)
  );

  // Capture the core result on accepted edges, hold it otherwise; reset wins over a simultaneous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= next_out;
      res       <= next_res;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shr_2.sv
// Scoreboard bench for shr_2: the driver pushes the expected post-edge state
// for every cycle it drives, and an independent monitor pops and compares.
module tb_shr_2;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] in;
  logic [1:0]   inadd;
  logic [W-1:0] out;
  logic [1:0]   res;
  logic         out_valid;

  typedef struct {
    logic         v;
    logic [W-1:0] o;
    logic [1:0]   r;
  } exp_t;

  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] m_out = '0;
  logic [1:0]   m_res = '0;

  shr_2 #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .in        (in),
    .inadd     (inadd),
    .out       (out),
    .res       (res),
    .out_valid (out_valid)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result from the operation's arithmetic meaning.
  function automatic logic [W-1:0] ref_out(input logic [1:0] md, input logic [W-1:0] d,
                                           input logic [1:0] ad);
    logic [W-1:0] a;
    a = W'(ad);
    case (md)
      2'd0:    return (a << (W - 2)) | (d >> 2);
      2'd1:    return W'($signed(d) >>> 2);
      2'd2:    return (d >> 2) | (d << (W - 2));
      default: return d;
    endcase
  endfunction

  function automatic logic [1:0] ref_res(input logic [1:0] md, input logic [W-1:0] d);
    return (md == 2'd3) ? 2'd0 : 2'(d % 4);
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs; push either the model's or an explicit expectation.
  task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] md,
                               input logic [W-1:0] d, input logic [1:0] ad,
                               input logic use_exp, input logic [W-1:0] eo,
                               input logic [1:0] er);
    exp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = iv;
    mode     = md;
    in       = d;
    inadd    = ad;
    if (r) begin
      m_out = '0;
      m_res = '0;
      e.v   = 1'b0;
    end else if (iv) begin
      m_out = use_exp ? eo : ref_out(md, d, ad);
      m_res = use_exp ? er : ref_res(md, d);
      e.v   = 1'b1;
    end else begin
      e.v   = 1'b0;
    end
    e.o = m_out;
    e.r = m_res;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [1:0] md,
                       input logic [W-1:0] d, input logic [1:0] ad);
    applyStimulus(r, iv, md, d, ad, 1'b0, '0, 2'b00);
  endtask

  task automatic expect_acc(input logic [1:0] md, input logic [W-1:0] d, input logic [1:0] ad,
                            input logic [W-1:0] eo, input logic [1:0] er);
    applyStimulus(1'b0, 1'b1, md, d, ad, 1'b1, eo, er);
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out_valid", W'(out_valid), W'(e.v));
        checkOutput("out", out, e.o);
        checkOutput("res", W'(res), W'(e.r));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL timeout: got running, expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; in = '0; inadd = 2'b00;
    drive(1'b1, 1'b0, 2'b00, '0, 2'b00);
    drive(1'b1, 1'b0, 2'b00, '0, 2'b00);

    expect_acc(2'b00, 8'b11001001, 2'b01, 8'b01110010, 2'b01);
    expect_acc(2'b01, 8'b10000110, 2'b00, 8'b11100001, 2'b10);
    expect_acc(2'b01, 8'b01000111, 2'b11, 8'b00010001, 2'b11);
    expect_acc(2'b10, 8'b00000011, 2'b10, 8'b11000000, 2'b11);
    expect_acc(2'b11, 8'hA5,       2'b11, 8'hA5,       2'b00);

    expect_acc(2'b00, 8'hFF, 2'b00, 8'h3F, 2'b11);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), W'($urandom), 2'($urandom_range(0, 3)));

    drive(1'b1, 1'b1, 2'b11, 8'h5A, 2'b01);
    expect_acc(2'b10, 8'h81, 2'b00, 8'h60, 2'b01);
    expect_acc(2'b00, 8'h0C, 2'b10, 8'h83, 2'b00);
    expect_acc(2'b01, 8'hF4, 2'b01, 8'hFD, 2'b00);

    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), W'($urandom), 2'($urandom_range(0, 3)));

    drive(1'b0, 1'b0, 2'b00, '0, 2'b00);
    @(posedge clk);
    #3;
    checkOutput("drain", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
